// File: rtl/_regfile32_wr_pkg.sv
// Shared sizes and FSM state encoding for the 32-entry register file.
package _regfile32_wr_pkg;
    localparam int BIT_WIDTH  = 16;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/_dec32.sv
// 5-to-32 one-hot decoder with enable; drives per-entry write or clear strobes.
module _dec32
    import _regfile32_wr_pkg::*;
(
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [REG_COUNT-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/_mux32.sv
// 32-input read mux over the packed entry array.
module _mux32
    import _regfile32_wr_pkg::*;
#(
    parameter int W = BIT_WIDTH
) (
    input  logic [REG_COUNT-1:0][W-1:0] d,
    input  logic [REG_ADDR_W-1:0]       sel,
    output logic [W-1:0]                y
);
    assign y = d[sel];
endmodule

// File: rtl/_regfile32_wr.sv
// 32-entry register file: one write port, two combinational read ports and a
// one-entry-per-cycle clear sweep that blocks writes while it runs.
module _regfile32_wr
    import _regfile32_wr_pkg::*;
#(
    parameter int n       = BIT_WIDTH,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [n-1:0]          wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [n-1:0]          rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [n-1:0]          rdata_b,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_drop
);
    state_t                      state, state_nx;
    logic [REG_ADDR_W-1:0]       cnt, cnt_nx;
    logic [REG_COUNT-1:0][n-1:0] entries;
    logic [REG_COUNT-1:0]        wr_oh, clr_oh;
    logic [n-1:0]                mux_a, mux_b;

    _dec32 u_wr_dec  (.en(we && !busy), .addr(waddr), .onehot(wr_oh));
    _dec32 u_clr_dec (.en(busy),        .addr(cnt),   .onehot(clr_oh));

    _mux32 #(.W(n)) u_mux_a (.d(entries), .sel(raddr_a), .y(mux_a));
    _mux32 #(.W(n)) u_mux_b (.d(entries), .sel(raddr_b), .y(mux_b));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = (state == CLEAR);
        case (state)
            IDLE: if (clr_req) begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end
            CLEAR: begin
                cnt_nx = cnt + 5'd1;
                if (cnt == 5'd31) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Clear and write strobes never coincide: the write decoder is gated by busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_drop <= 1'b0;
            entries <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            wr_drop <= we && busy;
            for (int i = 0; i < REG_COUNT; i++) begin
                if (clr_oh[i])
                    entries[i] <= '0;
                else if (wr_oh[i] && !(ZERO_R0 != 0 && i == 0))
                    entries[i] <= wdata;
            end
        end
    end

    // Hardwired zero wins over bypass so a write to r0 never leaks out.
    always_comb begin
        rdata_a = mux_a;
        if (ZERO_R0 != 0 && raddr_a == '0)
            rdata_a = '0;
        else if (BYPASS != 0 && we && !busy && waddr == raddr_a)
            rdata_a = wdata;
    end

    always_comb begin
        rdata_b = mux_b;
        if (ZERO_R0 != 0 && raddr_b == '0)
            rdata_b = '0;
        else if (BYPASS != 0 && we && !busy && waddr == raddr_b)
            rdata_b = wdata;
    end
endmodule

// File: tb/tb__regfile32_wr.sv
// Scoreboard bench for _regfile32_wr: bypassing and non-bypassing instances share inputs.
module tb__regfile32_wr;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [4:0]  raddr_a = '0, raddr_b = '0;
    logic        clr_req = 1'b0;
    logic [15:0] rdata_a, rdata_b, rdata_a_nb, rdata_b_nb;
    logic        busy, wr_drop, busy_nb, wr_drop_nb;

    int total = 0;
    int bad = 0;
    logic [15:0] mdl [32];
    logic [15:0] exp_q [$];
    logic [15:0] e;

    always #5 clk = ~clk;

    _regfile32_wr #(.n(16), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop));

    _regfile32_wr #(.n(16), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a_nb), .raddr_b(raddr_b), .rdata_b(rdata_b_nb),
        .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] xor_pat);
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; waddr = 5'(k); wdata = 16'(k) ^ xor_pat;
            tick();
            mdl[k] = 16'(k) ^ xor_pat;
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 16'h1234; clr_req = 1'b1;
        tick();
        tick();
        reset_n = 1'b1; we = 1'b0; clr_req = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || wr_drop !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b wr_drop=%b exp 0/0", busy, wr_drop);
        end
        for (int k = 0; k < 32; k++) begin
            mdl[k] = '0;
            raddr_a = 5'(k); raddr_b = 5'(31 - k);
            #1;
            exp_q.push_back(16'h0); exp_q.push_back(16'h0);
            e = exp_q.pop_front(); total++;
            if (rdata_a !== e) begin bad++; $display("FAIL reset_rd_a addr=%0d got=%h exp=%h", k, rdata_a, e); end
            e = exp_q.pop_front(); total++;
            if (rdata_b !== e) begin bad++; $display("FAIL reset_rd_b addr=%0d got=%h exp=%h", 31 - k, rdata_b, e); end
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd5; wdata = 16'hA5A5; raddr_a = 5'd5; raddr_b = 5'd6;
        #1;
        exp_q.push_back(16'hA5A5); exp_q.push_back(mdl[5]); exp_q.push_back(mdl[6]);
        e = exp_q.pop_front(); total++;
        if (rdata_a !== e) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", rdata_a, e); end
        e = exp_q.pop_front(); total++;
        if (rdata_a_nb !== e) begin bad++; $display("FAIL nobypass_same_cycle got=%h exp=%h", rdata_a_nb, e); end
        e = exp_q.pop_front(); total++;
        if (rdata_b !== e) begin bad++; $display("FAIL bypass_other_port got=%h exp=%h", rdata_b, e); end
        tick();
        mdl[5] = 16'hA5A5;
        we = 1'b0;
        #1;
        exp_q.push_back(mdl[5]); exp_q.push_back(mdl[5]);
        e = exp_q.pop_front(); total++;
        if (rdata_a_nb !== e) begin bad++; $display("FAIL nobypass_next_cycle got=%h exp=%h", rdata_a_nb, e); end
        e = exp_q.pop_front(); total++;
        if (rdata_a !== e) begin bad++; $display("FAIL bypass_stored got=%h exp=%h", rdata_a, e); end
    endtask

    task automatic test_zero_r0();
        we = 1'b1; waddr = 5'd0; wdata = 16'hFFFF; raddr_a = 5'd0; raddr_b = 5'd5;
        #1;
        exp_q.push_back(16'h0);
        e = exp_q.pop_front(); total++;
        if (rdata_a !== e) begin bad++; $display("FAIL r0_before_edge got=%h exp=%h", rdata_a, e); end
        tick();
        we = 1'b0;
        #1;
        exp_q.push_back(16'h0); exp_q.push_back(16'h0);
        e = exp_q.pop_front(); total++;
        if (rdata_a !== e) begin bad++; $display("FAIL r0_after_edge got=%h exp=%h", rdata_a, e); end
        e = exp_q.pop_front(); total++;
        if (rdata_a_nb !== e) begin bad++; $display("FAIL r0_after_edge_nb got=%h exp=%h", rdata_a_nb, e); end
        total++;
        if (wr_drop !== 1'b0) begin bad++; $display("FAIL r0_wr_drop got=%b exp=0", wr_drop); end
    endtask

    task automatic test_clear_sweep();
        fill(16'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 32; c++) begin
            raddr_a = 5'(c);
            raddr_b = (c == 0) ? 5'd31 : (c == 10) ? 5'd3 : 5'(c - 1);
            we = (c == 10); waddr = 5'd3; wdata = 16'hBEEF;
            #1;
            exp_q.push_back(mdl[c]);
            exp_q.push_back((c == 0) ? mdl[31] : 16'h0);
            e = exp_q.pop_front(); total++;
            if (rdata_a !== e) begin bad++; $display("FAIL sweep_rd_a cyc=%0d got=%h exp=%h", c, rdata_a, e); end
            e = exp_q.pop_front(); total++;
            if (rdata_b !== e) begin bad++; $display("FAIL sweep_rd_b cyc=%0d got=%h exp=%h", c, rdata_b, e); end
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL sweep_busy cyc=%0d got=%b exp=1", c, busy); end
            total++;
            if (wr_drop !== (c == 11)) begin bad++; $display("FAIL sweep_wr_drop cyc=%0d got=%b exp=%b", c, wr_drop, (c == 11)); end
            tick();
            mdl[c] = '0;
        end
        we = 1'b0; raddr_a = 5'd3; raddr_b = 5'd31;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL sweep_end_busy got=%b exp=0", busy); end
        exp_q.push_back(mdl[3]); exp_q.push_back(mdl[31]);
        e = exp_q.pop_front(); total++;
        if (rdata_a !== e) begin bad++; $display("FAIL sweep_entry3 got=%h exp=%h", rdata_a, e); end
        e = exp_q.pop_front(); total++;
        if (rdata_b !== e) begin bad++; $display("FAIL sweep_entry31 got=%h exp=%h", rdata_b, e); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill(16'h5A00);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        for (int k = 0; k < 32; k++) begin
            mdl[k] = '0;
            raddr_a = 5'(k); raddr_b = 5'(k);
            #1;
            exp_q.push_back(mdl[k]); exp_q.push_back(mdl[k]);
            e = exp_q.pop_front(); total++;
            if (rdata_a !== e) begin bad++; $display("FAIL rst_mid_rd_a addr=%0d got=%h exp=%h", k, rdata_a, e); end
            e = exp_q.pop_front(); total++;
            if (rdata_b_nb !== e) begin bad++; $display("FAIL rst_mid_rd_b addr=%0d got=%h exp=%h", k, rdata_b_nb, e); end
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        total++;
        if (n != 32) begin bad++; $display("FAIL rst_mid_resweep_len got=%0d exp=32", n); end
    endtask

    task automatic test_clr_hold();
        int n;
        logic exp_busy;
        clr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            exp_busy = (i != 32);
            total++;
            if (busy !== exp_busy) begin bad++; $display("FAIL hold_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy); end
        end
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 64) begin n++; tick(); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_sweep_timeout got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_r0();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_clr_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/_regfile32_wr.md
Name: _regfile32_wr

Overview:
- 32-entry, n-bit register bank driven by a one-hot write decoder. The decoder is the demultiplexing counterpart of the 32-input read mux.
- Provides one synchronous write port, two combinational read ports and a sequenced clear engine that zeroes entries one per cycle.
- Sits in the CPU datapath as the general-purpose register file. Decode issues reads; writeback issues writes and clears.

Parameters:
- n, BIT_WIDTH, data width of each entry and of all data ports.
- ZERO_R0, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising clk.
- we  input  1  write enable.
- waddr  input  5  write address.
- wdata  input  n  write data.
- raddr_a  input  5  read port A address.
- rdata_a  output  n  read port A data.
- raddr_b  input  5  read port B address.
- rdata_b  output  n  read port B data.
- clr_req  input  1  start a full-bank clear; one-cycle pulse or level.
- busy  output  1  clear sweep in progress.
- wr_drop  output  1  registered; pulses 1 cycle after a write dropped because busy was 1.

Behaviour:
- Reset (reset_n=0 at edge): all 32 entries go to 0, FSM goes to IDLE, clear counter goes to 0, busy=0, wr_drop=0.
  - Reset overrides clr_req and we in the same cycle.
  - Reset mid-sweep aborts the sweep; all entries are 0 after the edge regardless.
- Write, IDLE: when we=1, entry[waddr] <= wdata at the edge. The decoder is 32 one-hot enables; exactly one entry is updated.
  - With ZERO_R0=1 and waddr=0 the write is discarded silently; wr_drop is not asserted.
- Read: rdata_x = entry[raddr_x], combinational, zero latency.
  - With ZERO_R0=1 and raddr_x=0, output is 0.
  - With BYPASS=1, we=1, busy=0, waddr=raddr_x and waddr!=0 (or ZERO_R0=0), output is wdata in the same cycle.
  - With BYPASS=0 the new value is visible the cycle after the write edge.
- FSM states:
  - IDLE: busy=0. clr_req=1 at the edge moves to CLEAR with cnt <= 0. A write in that same cycle is performed, then overwritten by the sweep.
  - CLEAR: busy=1. Each edge: entry[cnt] <= 0, cnt <= cnt+1 (5-bit, wraps 31->0). After the edge that clears entry 31, return to IDLE.
  - A sweep therefore takes exactly 32 cycles; busy is 1 for 32 cycles.
- clr_req during CLEAR is ignored; no restart or extension.
- Writes during CLEAR (busy=1, we=1) are dropped, and wr_drop=1 on the following cycle.
- Reads during CLEAR return current contents: already-cleared entries read 0, the rest hold old data. Bypass is disabled while busy=1.
- A write and a clear-slot to the same entry cannot collide, because writes are blocked while busy=1.

Decomposition:
- Shared package: BIT_WIDTH (existing), REG_COUNT=32, REG_ADDR_W=5, and the FSM state enum {IDLE, CLEAR}.
- Read ports: two instances of _mux32 #(n) fed by the 32 entry vectors, plus the bypass/zero override logic in the parent.
- Write side: a small sub-module _dec32 (5-to-32 one-hot decoder with enable) is natural and is shared with the clear counter path.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rdata = 0, busy=0, wr_drop=0.
- Write waddr=5 wdata=0xA5A5 with we=1, raddr_a=5, BYPASS=1 -> rdata_a=0xA5A5 in the same cycle; with BYPASS=0 it appears the next cycle; raddr_b=6 stays 0.
- ZERO_R0=1: write waddr=0 wdata=0xFFFF -> rdata_a(raddr=0)=0 before and after the edge; wr_drop stays 0.
- Fill entries 1..31 with value=index, pulse clr_req for 1 cycle, write waddr=3 at sweep cycle 10 ->
  - busy high exactly 32 cycles.
  - entry k reads 0 from cycle k+1 of the sweep, otherwise k.
  - wr_drop pulses 1 cycle after the write; entry 3 ends at 0.
- Start a sweep, deassert reset_n at sweep cycle 7 for 1 cycle -> all entries 0, busy=0 on the next cycle; re-pulse clr_req -> full 32-cycle sweep again.
- Hold clr_req high for 40 cycles -> first sweep of 32 cycles, IDLE for 1 cycle, then a second sweep starts.
